serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, purely combinational (zero latency, no flow control).
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = a - b, LSB first; result valid WIDTH edges after start.
// No backpressure: start is only sampled in IDLE/DONE and ignored while busy.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-2:0] dsr_q, dsr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;

  logic             diff_bit;
  logic             bout_bit;
  logic [WIDTH-1:0] shifted;

  full_subtractor u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .diff (diff_bit),
    .bout (bout_bit)
  );

  // The final diff bit goes straight into d, so the shift register keeps only WIDTH-1 bits.
  assign shifted = {diff_bit, dsr_q};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dsr_d   = dsr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bo_d    = bo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          dsr_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        dsr_d = shifted[WIDTH-1:1];
        br_d  = bout_bit;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          d_d     = shifted;
          bo_d    = bout_bit;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      dsr_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dsr_q   <= dsr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

  assign d    = d_q;
  assign bo   = bo_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule
